// File: rtl/scan_seq3.sv
// Address scanner for a 3-to-8 decoder: walks A up or down, holding each
// address for DWELL cycles, in single-pass or continuous mode.
module scan_seq3 #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       dir,
  input  logic       hold,
  output logic [2:0] A,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_a;
  logic       r_mode;
  logic       r_dir;
  logic       r_busy;
  logic       r_done;
  logic       r_wrap;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [2:0] w_a_nxt;
  logic       w_mode_nxt;
  logic       w_dir_nxt;
  logic       w_wrap_ev;
  logic       w_last_addr;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_wrap_nxt;

  // The address the current direction leaves last (7 going up, 0 going down).
  assign w_last_addr = r_dir ? (r_a == 3'd0) : (r_a == 3'd7);

  // State and all outputs are registered; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_a     <= 3'd0;
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_mode  <= w_mode_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state logic: stop beats hold, hold beats a dwell step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_wrap_ev   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 8'd0;
          w_a_nxt     = dir ? 3'd7 : 3'd0;
          w_mode_nxt  = mode;
          w_dir_nxt   = dir;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
          w_a_nxt     = 3'd0;
        end else if (hold) begin
          w_state_nxt = S_RUN;
        end else if (r_cnt == LAST_CNT) begin
          w_cnt_nxt = 8'd0;
          if (w_last_addr && !r_mode) begin
            w_state_nxt = S_DONE;
          end else begin
            w_a_nxt   = r_dir ? (r_a - 3'd1) : (r_a + 3'd1);
            w_wrap_ev = w_last_addr;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state, so flags line up with A.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_wrap_nxt = w_wrap_ev;
  end

  assign A    = r_a;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
